// File: rtl/pe_tile_dispatch_if.sv
// Tile handshake bundle between the Winograd PE array, the dispatcher and the CIM lanes.
// Upstream side: in_tile_i / in_od_i / in_valid_i with in_ready_o back-pressure.
// Downstream side: two one-cycle-strobe lanes carrying tile, od and memory address.
interface pe_tile_dispatch_if;
   logic [431:0] in_tile_i;
   logic [7:0]   in_od_i;
   logic         in_valid_i;
   logic         in_ready_o;

   logic [431:0] PE_tile_o_1;
   logic [431:0] PE_tile_o_2;
   logic [7:0]   PE_od_o_1;
   logic [7:0]   PE_od_o_2;
   logic [7:0]   PE_addr_o_1;
   logic [7:0]   PE_addr_o_2;
   logic         PE_valid_o_1;
   logic         PE_valid_o_2;

   // Dispatcher view.
   modport slave (
      input  in_tile_i, in_od_i, in_valid_i,
      output in_ready_o,
      output PE_tile_o_1, PE_tile_o_2, PE_od_o_1, PE_od_o_2,
      output PE_addr_o_1, PE_addr_o_2, PE_valid_o_1, PE_valid_o_2
   );

   // Producer/consumer view (PE array plus CIM lanes).
   modport master (
      output in_tile_i, in_od_i, in_valid_i,
      input  in_ready_o,
      input  PE_tile_o_1, PE_tile_o_2, PE_od_o_1, PE_od_o_2,
      input  PE_addr_o_1, PE_addr_o_2, PE_valid_o_1, PE_valid_o_2
   );
endinterface

// File: rtl/pe_tile_dispatch.sv
// Purpose: in-order tile FIFO issuing up to two tiles/cycle to CIM lanes, holding back
//          any od still inside the HAZ_WIN-cycle read-modify-write lock window.
// Latency: 1 edge from push (into empty, unlocked FIFO) to registered lane-1 strobe.
// Backpressure: in_ready_o = (count < DEPTH), independent of same-cycle pops.
// Ports: clk, rst_n (sync, active-low); bus (slave modport: input tile/od/valid,
//        ready, two lanes of tile/od/addr/valid); count_o occupancy; busy_o activity.
module pe_tile_dispatch #(
   parameter int          DEPTH       = 4,
   parameter int          HAZ_WIN     = 2,
   parameter logic [7:0]  ADDR_OFFSET = 8'd0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   pe_tile_dispatch_if.slave          bus,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       busy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // FIFO storage and pointers
   logic [431:0]  tile_mem_q [DEPTH];
   logic [431:0]  tile_mem_d [DEPTH];
   logic [7:0]    od_mem_q   [DEPTH];
   logic [7:0]    od_mem_d   [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   // Lock history: slot 0 holds the dispatches of the most recent edge,
   // slot HAZ_WIN-1 the oldest still blocking. Index [1] is the lane-2 dispatch.
   logic [7:0]    hist_od_q  [HAZ_WIN][2];
   logic [7:0]    hist_od_d  [HAZ_WIN][2];
   logic          hist_vld_q [HAZ_WIN][2];
   logic          hist_vld_d [HAZ_WIN][2];

   // Registered lane outputs
   logic          vld1_q, vld1_d, vld2_q, vld2_d;
   logic [431:0]  tile1_q, tile1_d, tile2_q, tile2_d;
   logic [7:0]    od1_q, od1_d, od2_q, od2_d;
   logic [7:0]    addr1_q, addr1_d, addr2_q, addr2_d;

   // Dispatch decision
   logic [AW-1:0] h1_ptr;
   logic [7:0]    h0_od, h1_od;
   logic [431:0]  h0_tile, h1_tile;
   logic          h0_lock, h1_lock, hist_any;
   logic          push, pop0, pop1;

   always_comb begin
      h1_ptr   = rd_ptr_q + AW'(1);
      h0_od    = od_mem_q[rd_ptr_q];
      h1_od    = od_mem_q[h1_ptr];
      h0_tile  = tile_mem_q[rd_ptr_q];
      h1_tile  = tile_mem_q[h1_ptr];
      h0_lock  = 1'b0;
      h1_lock  = 1'b0;
      hist_any = 1'b0;
      for (int s = 0; s < HAZ_WIN; s++) begin
         for (int l = 0; l < 2; l++) begin
            if (hist_vld_q[s][l]) begin
               hist_any = 1'b1;
               if (hist_od_q[s][l] == h0_od) h0_lock = 1'b1;
               if (hist_od_q[s][l] == h1_od) h1_lock = 1'b1;
            end
         end
      end
      push = bus.in_valid_i && (count_q < CW'(DEPTH));
      pop0 = (count_q != '0) && !h0_lock;
      // H1 only rides along with H0; equal ods would collide in the RMW loop.
      pop1 = pop0 && (count_q >= CW'(2)) && (h1_od != h0_od) && !h1_lock;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop0) + AW'(pop1);
      count_d    = count_q + CW'(push) - CW'(pop0) - CW'(pop1);
      tile_mem_d = tile_mem_q;
      od_mem_d   = od_mem_q;
      if (push) begin
         tile_mem_d[wr_ptr_q] = bus.in_tile_i;
         od_mem_d[wr_ptr_q]   = bus.in_od_i;
      end

      hist_od_d  = hist_od_q;
      hist_vld_d = hist_vld_q;
      for (int s = HAZ_WIN - 1; s > 0; s--) begin
         hist_od_d[s]  = hist_od_q[s-1];
         hist_vld_d[s] = hist_vld_q[s-1];
      end
      hist_od_d[0][0]  = h0_od;
      hist_vld_d[0][0] = pop0;
      hist_od_d[0][1]  = h1_od;
      hist_vld_d[0][1] = pop1;

      // Data buses hold the last dispatched tile while the strobe is low.
      vld1_d  = pop0;
      vld2_d  = pop1;
      tile1_d = pop0 ? h0_tile : tile1_q;
      od1_d   = pop0 ? h0_od : od1_q;
      addr1_d = pop0 ? (h0_od + ADDR_OFFSET) : addr1_q;
      tile2_d = pop1 ? h1_tile : tile2_q;
      od2_d   = pop1 ? h1_od : od2_q;
      addr2_d = pop1 ? (h1_od + ADDR_OFFSET) : addr2_q;
   end

   // Storage array carries no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      tile_mem_q <= tile_mem_d;
      od_mem_q   <= od_mem_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         hist_od_q  <= '{default: '0};
         hist_vld_q <= '{default: '0};
         vld1_q     <= 1'b0;
         vld2_q     <= 1'b0;
         tile1_q    <= '0;
         tile2_q    <= '0;
         od1_q      <= '0;
         od2_q      <= '0;
         addr1_q    <= '0;
         addr2_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         hist_od_q  <= hist_od_d;
         hist_vld_q <= hist_vld_d;
         vld1_q     <= vld1_d;
         vld2_q     <= vld2_d;
         tile1_q    <= tile1_d;
         tile2_q    <= tile2_d;
         od1_q      <= od1_d;
         od2_q      <= od2_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
      end
   end

   assign bus.in_ready_o   = (count_q < CW'(DEPTH));
   assign bus.PE_valid_o_1 = vld1_q;
   assign bus.PE_valid_o_2 = vld2_q;
   assign bus.PE_tile_o_1  = tile1_q;
   assign bus.PE_tile_o_2  = tile2_q;
   assign bus.PE_od_o_1    = od1_q;
   assign bus.PE_od_o_2    = od2_q;
   assign bus.PE_addr_o_1  = addr1_q;
   assign bus.PE_addr_o_2  = addr2_q;
   assign count_o          = count_q;
   assign busy_o           = (count_q != '0) | hist_any;
endmodule

// File: tb/tb_pe_tile_dispatch.sv
module tb_pe_tile_dispatch;
   localparam int DEPTH = 4;
   localparam int HAZ   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [431:0] d_tile;
   logic [7:0]   d_od;
   logic         d_vld;
   logic [2:0]   cnt0, cnt1;
   logic         busy0, busy1;

   pe_tile_dispatch_if if0 ();
   pe_tile_dispatch_if if1 ();
   assign if0.in_tile_i  = d_tile;
   assign if0.in_od_i    = d_od;
   assign if0.in_valid_i = d_vld;
   assign if1.in_tile_i  = d_tile;
   assign if1.in_od_i    = d_od;
   assign if1.in_valid_i = d_vld;

   pe_tile_dispatch #(.DEPTH(DEPTH), .HAZ_WIN(HAZ), .ADDR_OFFSET(8'd0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave), .count_o(cnt0), .busy_o(busy0));
   pe_tile_dispatch #(.DEPTH(DEPTH), .HAZ_WIN(HAZ), .ADDR_OFFSET(8'd1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave), .count_o(cnt1), .busy_o(busy1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chkt(input string nm, input logic [431:0] act, input logic [431:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [431:0] mk_tile(input int s);
      logic [431:0] t;
      for (int k = 0; k < 36; k++) t[k*12 +: 12] = 12'(s * 151 + k * 37 - 600);
      return t;
   endfunction

   // ---------------- reference model: FIFO queue + per-od last-dispatch timestamp
   typedef struct packed { logic [431:0] tile; logic [7:0] od; } ent_t;
   ent_t         mq[$];
   int           last_disp[256];
   int           ecnt = 0;
   bit           started = 0;
   logic         m_v1, m_v2;
   logic [431:0] m_t1, m_t2;
   logic [7:0]   m_o1, m_o2;
   logic [7:0]   m_a1[2], m_a2[2];
   int           m_cnt;
   logic         m_busy;

   always @(posedge clk) begin
      int  e;
      bit  e0, e1, can_push;
      e = ecnt;
      ecnt++;
      if (!rst_n) begin
         started = 1;
         mq.delete();
         foreach (last_disp[i]) last_disp[i] = -1000;
         m_v1 = 0; m_v2 = 0; m_t1 = '0; m_t2 = '0; m_o1 = '0; m_o2 = '0;
         m_a1[0] = '0; m_a1[1] = '0; m_a2[0] = '0; m_a2[1] = '0;
         m_cnt = 0; m_busy = 0;
      end else begin
         can_push = (mq.size() < DEPTH);
         e0 = (mq.size() >= 1) && (e - last_disp[mq[0].od] > HAZ);
         e1 = e0 && (mq.size() >= 2) && (mq[1].od != mq[0].od) && (e - last_disp[mq[1].od] > HAZ);
         m_v1 = e0;
         m_v2 = e1;
         if (e0) begin
            m_t1 = mq[0].tile; m_o1 = mq[0].od;
            m_a1[0] = mq[0].od; m_a1[1] = mq[0].od + 8'd1;
            last_disp[mq[0].od] = e;
         end
         if (e1) begin
            m_t2 = mq[1].tile; m_o2 = mq[1].od;
            m_a2[0] = mq[1].od; m_a2[1] = mq[1].od + 8'd1;
            last_disp[mq[1].od] = e;
            void'(mq.pop_front());
         end
         if (e0) void'(mq.pop_front());
         if (d_vld && can_push) mq.push_back('{d_tile, d_od});
         m_cnt  = mq.size();
         m_busy = (m_cnt != 0);
         foreach (last_disp[i]) if (last_disp[i] > e - HAZ) m_busy = 1;
      end
   end

   // ---------------- compare process and strobe log
   typedef struct { int e; logic [7:0] od; logic [7:0] a0; logic [7:0] a1; logic [431:0] tile; } ev_t;
   ev_t log1[$];
   ev_t log2[$];

   always @(negedge clk) begin
      if (started) begin
         chk("v1_0", 32'(if0.PE_valid_o_1), 32'(m_v1));
         chk("v2_0", 32'(if0.PE_valid_o_2), 32'(m_v2));
         chk("v1_1", 32'(if1.PE_valid_o_1), 32'(m_v1));
         chk("v2_1", 32'(if1.PE_valid_o_2), 32'(m_v2));
         chkt("tile1_0", if0.PE_tile_o_1, m_t1);
         chkt("tile2_0", if0.PE_tile_o_2, m_t2);
         chkt("tile1_1", if1.PE_tile_o_1, m_t1);
         chkt("tile2_1", if1.PE_tile_o_2, m_t2);
         chk("od1_0", 32'(if0.PE_od_o_1), 32'(m_o1));
         chk("od2_0", 32'(if0.PE_od_o_2), 32'(m_o2));
         chk("od1_1", 32'(if1.PE_od_o_1), 32'(m_o1));
         chk("od2_1", 32'(if1.PE_od_o_2), 32'(m_o2));
         chk("addr1_0", 32'(if0.PE_addr_o_1), 32'(m_a1[0]));
         chk("addr2_0", 32'(if0.PE_addr_o_2), 32'(m_a2[0]));
         chk("addr1_1", 32'(if1.PE_addr_o_1), 32'(m_a1[1]));
         chk("addr2_1", 32'(if1.PE_addr_o_2), 32'(m_a2[1]));
         chk("ready_0", 32'(if0.in_ready_o), 32'(m_cnt < DEPTH));
         chk("ready_1", 32'(if1.in_ready_o), 32'(m_cnt < DEPTH));
         chk("count_0", 32'(cnt0), 32'(m_cnt));
         chk("count_1", 32'(cnt1), 32'(m_cnt));
         chk("busy_0", 32'(busy0), 32'(m_busy));
         chk("busy_1", 32'(busy1), 32'(m_busy));
         if (if0.PE_valid_o_1 === 1'b1)
            log1.push_back('{ecnt - 1, if0.PE_od_o_1, if0.PE_addr_o_1, if1.PE_addr_o_1, if0.PE_tile_o_1});
         if (if0.PE_valid_o_2 === 1'b1)
            log2.push_back('{ecnt - 1, if0.PE_od_o_2, if0.PE_addr_o_2, if1.PE_addr_o_2, if0.PE_tile_o_2});
      end
   end

   // ---------------- stimulus helpers
   int tbase;

   task automatic step(input logic v, input logic [7:0] od, input logic [431:0] t);
      d_vld  = v;
      d_od   = od;
      d_tile = t;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, '0);
   endtask

   // Hand-computed strobe expectation: lane, index in log, edge relative to tbase, od.
   task automatic lchk(input string nm, input int lane, input int idx, input int rel_e,
                       input logic [7:0] od);
      ev_t ev;
      bit  have;
      have = 0;
      if (lane == 1 && idx < log1.size()) begin ev = log1[idx]; have = 1; end
      if (lane == 2 && idx < log2.size()) begin ev = log2[idx]; have = 1; end
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL %s no strobe lane %0d index %0d", nm, lane, idx);
      end else begin
         chk({nm, "_edge"}, 32'(ev.e - tbase), 32'(rel_e));
         chk({nm, "_od"}, 32'(ev.od), 32'(od));
         chk({nm, "_addr_off0"}, 32'(ev.a0), 32'(od));
         chk({nm, "_addr_off1"}, 32'(ev.a1), 32'(8'(od + 8'd1)));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_full;
      // --- reset held 3 edges with valid data presented
      rst_n  = 1'b0;
      d_vld  = 1'b1;
      d_od   = 8'd42;
      d_tile = mk_tile(99);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 32'(cnt0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_v1", 32'(if0.PE_valid_o_1), 32'd0);
      chkt("rst_tile1", if0.PE_tile_o_1, '0);
      chk("rst_addr1_off1", 32'(if1.PE_addr_o_1), 32'd0);
      log1.delete(); log2.delete();
      rst_n = 1'b1;
      d_vld = 1'b0;
      chk("rst_ready_after", 32'(if0.in_ready_o), 32'd1);
      idle(4);
      chk("rst_no_dispatch", 32'(log1.size() + log2.size()), 32'd0);

      // --- single tile od=5
      log1.delete(); log2.delete();
      tbase = ecnt;
      step(1'b1, 8'd5, mk_tile(1));
      idle(2);
      chk("single_busy_e2", 32'(busy0), 32'd1);
      idle(1);
      chk("single_busy_e3", 32'(busy0), 32'd0);
      idle(3);
      chk("single_n1", 32'(log1.size()), 32'd1);
      chk("single_n2", 32'(log2.size()), 32'd0);
      lchk("single", 1, 0, 1, 8'd5);
      if (log1.size() > 0) chkt("single_tile", log1[0].tile, mk_tile(1));

      // --- ods 7,7,8,9
      log1.delete(); log2.delete();
      tbase = ecnt;
      step(1'b1, 8'd7, mk_tile(2));
      step(1'b1, 8'd7, mk_tile(3));
      step(1'b1, 8'd8, mk_tile(4));
      step(1'b1, 8'd9, mk_tile(5));
      idle(8);
      chk("haz_n1", 32'(log1.size()), 32'd3);
      chk("haz_n2", 32'(log2.size()), 32'd1);
      lchk("haz_l1a", 1, 0, 1, 8'd7);
      lchk("haz_l1b", 1, 1, 4, 8'd7);
      lchk("haz_l1c", 1, 2, 5, 8'd9);
      lchk("haz_l2a", 2, 0, 4, 8'd8);

      // --- backlog of same od until full
      log1.delete(); log2.delete();
      tbase = ecnt;
      saw_full = 0;
      for (int i = 0; i < 8; i++) begin
         int tries;
         bit acc;
         tries = 0;
         do begin
            acc = if0.in_ready_o;
            if (!acc) begin
               saw_full = 1;
               chk("full_count", 32'(cnt0), 32'd4);
            end
            step(1'b1, 8'd3, mk_tile(10 + i));
            tries++;
         end while (!acc && tries < 20);
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL backlog_push tile %0d never accepted", i);
         end
      end
      idle(30);
      chk("full_seen", 32'(saw_full), 32'd1);
      chk("backlog_n1", 32'(log1.size()), 32'd8);
      chk("backlog_n2", 32'(log2.size()), 32'd0);
      for (int i = 0; i < 8 && i < log1.size(); i++) begin
         chkt("backlog_order", log1[i].tile, mk_tile(10 + i));
         if (i > 0) chk("backlog_gap", 32'(log1[i].e - log1[i-1].e), 32'(HAZ + 1));
      end

      // --- address wrap
      log1.delete(); log2.delete();
      tbase = ecnt;
      step(1'b1, 8'd255, mk_tile(50));
      idle(4);
      lchk("wrap", 1, 0, 1, 8'd255);
      if (log1.size() > 0) chk("wrap_addr_literal", 32'(log1[0].a1), 32'd0);

      // --- reset mid-operation
      log1.delete(); log2.delete();
      tbase = ecnt;
      for (int i = 0; i < 4; i++) step(1'b1, 8'd20, mk_tile(60 + i));
      chk("mid_pre_count", 32'(cnt0), 32'd3);
      rst_n = 1'b0;
      step(1'b0, 8'd0, '0);
      chk("mid_rst_count", 32'(cnt0), 32'd0);
      chk("mid_rst_v1", 32'(if0.PE_valid_o_1), 32'd0);
      rst_n = 1'b1;
      step(1'b1, 8'd20, mk_tile(64));
      idle(4);
      chk("mid_n1", 32'(log1.size()), 32'd2);
      chk("mid_n2", 32'(log2.size()), 32'd0);
      lchk("mid_a", 1, 0, 1, 8'd20);
      lchk("mid_b", 1, 1, 6, 8'd20);
      if (log1.size() > 1) chkt("mid_tile", log1[1].tile, mk_tile(64));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
